branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 94 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// plus misprediction pulse, flush request and resolved-branch statistics.
module branch_predictor #(
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    output logic        mispredict,
    output logic        flush,
    output logic [15:0] branch_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned FC_W  = 3;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0]       ctr_q [ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             miss_c;
    logic [FC_W-1:0]  flush_cnt_q;
    logic [FC_W-1:0]  flush_cnt_d;

    // Untagged table: only the index bits of either PC matter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign fetch_idx  = fetch_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign pred_taken = ctr_q[fetch_idx][1];
    assign miss_c     = upd_valid & (upd_taken ^ upd_pred);

    // Counter table; the write lands on the edge closing the update cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
                ctr_q[upd_idx] <= 2'(ctr_q[upd_idx] + 2'd1);
            end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
                ctr_q[upd_idx] <= 2'(ctr_q[upd_idx] - 2'd1);
            end
        end
    end

    // A new misprediction reloads the flush window, so back-to-back misses never gap.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (miss_c) begin
            flush_cnt_d = FC_W'(FLUSH_CYCLES);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = FC_W'(flush_cnt_q - FC_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
            flush       <= 1'b0;
            mispredict  <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            flush       <= (flush_cnt_d != '0);
            mispredict  <= miss_c;
        end
    end

    // Saturating statistics; misses only advance alongside a branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (upd_valid) begin
            if (branch_cnt != CNT_MAX) begin
                branch_cnt <= 16'(branch_cnt + 16'd1);
            end
            if (miss_c && miss_cnt != CNT_MAX) begin
                miss_cnt <= 16'(miss_cnt + 16'd1);
            end
        end
    end

endmodule
